// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues req/ack fetches to instruction
// memory and hands each instruction plus its PC to decode over valid/ready.
module fetch_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_word_q, inst_word_d;
  logic [63:0] inst_pc_q, inst_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_q, misalign_d;
  logic [63:0] redir_tgt_s;

  // Redirect targets are word-aligned before use; the low bits only feed the error pulse.
  assign redir_tgt_s = {redirect_pc[63:2], 2'b00};

  // Next-state, PC selection and capture of the fetched instruction.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    kill_d        = kill_q;
    inst_word_d   = inst_word_q;
    inst_pc_d     = inst_pc_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = redirect_valid & (redirect_pc[1:0] != 2'b00);

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect_valid) begin
          pc_d = redir_tgt_s;
        end else begin
          pc_d = pc_q;
        end
      end

      ST_FETCH: begin
        if (imem_ack) begin
          // A redirect landing with the ack beats any older pending target.
          if (redirect_valid) begin
            pc_d   = redir_tgt_s;
            kill_d = 1'b0;
          end else if (kill_q) begin
            pc_d   = pend_pc_q;
            kill_d = 1'b0;
          end else begin
            inst_word_d = imem_rdata;
            inst_pc_d   = pc_q;
            state_d     = ST_VALID;
          end
        end else if (redirect_valid) begin
          // The outstanding request must finish at pc_q, so park the target.
          kill_d    = 1'b1;
          pend_pc_d = redir_tgt_s;
        end else begin
          kill_d = kill_q;
        end
      end

      ST_VALID: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt_s;
          state_d = ST_FETCH;
        end else if (inst_ready) begin
          pc_d          = pc_q + 64'd4;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = ST_FETCH;
        end else begin
          state_d = ST_VALID;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      pend_pc_q     <= 64'h0;
      kill_q        <= 1'b0;
      inst_word_q   <= 32'h0;
      inst_pc_q     <= 64'h0;
      fetch_count_q <= 32'h0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_pc_q     <= pend_pc_d;
      kill_q        <= kill_d;
      inst_word_q   <= inst_word_d;
      inst_pc_q     <= inst_pc_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  // While killed, pc_q is untouched, so it is still the held request address.
  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign inst_valid   = (state_q == ST_VALID);
  assign inst_word    = inst_word_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic, all
// compared cycle by cycle against a transaction-level reference model.
module tb_fetch_sequencer;

  localparam logic [63:0] RV = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;

  fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_word(inst_word), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: one outstanding fetch, an optional held instruction, and
  // an optional "redirect owed" target that replaces the PC once the fetch lands.
  logic        m_boot, m_req, m_val, m_owed, m_mis;
  logic [63:0] m_pc, m_owed_pc, m_ipc;
  logic [31:0] m_word, m_count;

  task automatic model_reset();
    m_boot = 1'b1; m_req = 1'b0; m_val = 1'b0; m_owed = 1'b0; m_mis = 1'b0;
    m_pc = RV; m_owed_pc = 64'h0; m_ipc = 64'h0; m_word = 32'h0; m_count = 32'h0;
  endtask

  task automatic model_step(input logic a, input logic rv, input logic [63:0] rp, input logic rd);
    logic [63:0] tgt;
    tgt = rp & ~64'h3;
    m_mis = rv && (rp[1:0] != 2'b00);
    if (m_boot) begin
      m_boot = 1'b0;
      m_req = 1'b1;
      if (rv) m_pc = tgt;
    end else if (m_req) begin
      if (a) begin
        if (rv) begin
          m_pc = tgt; m_owed = 1'b0;
        end else if (m_owed) begin
          m_pc = m_owed_pc; m_owed = 1'b0;
        end else begin
          m_word = mem_word(m_pc); m_ipc = m_pc; m_req = 1'b0; m_val = 1'b1;
        end
      end else if (rv) begin
        m_owed = 1'b1; m_owed_pc = tgt;
      end
    end else if (m_val) begin
      if (rv) begin
        m_pc = tgt; m_val = 1'b0; m_req = 1'b1;
      end else if (rd) begin
        m_pc = m_pc + 64'd4; m_count = m_count + 32'd1; m_val = 1'b0; m_req = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {63'd0, imem_req}, {63'd0, m_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, m_val});
    chk("inst_word", {32'd0, inst_word}, {32'd0, m_word});
    chk("inst_pc", inst_pc, m_ipc);
    chk("misalign_err", {63'd0, misalign_err}, {63'd0, m_mis});
    chk("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
  endtask

  // Called at a negedge: drive one cycle of inputs, step the model, compare.
  task automatic cyc(input logic a, input logic rv, input logic [63:0] rp, input logic rd);
    imem_ack = a; redirect_valid = rv; redirect_pc = rp; inst_ready = rd;
    @(posedge clk);
    model_step(a, rv, rp, rd);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_addr", imem_addr, RV);
    chk("rst_inst_pc", inst_pc, 64'h0);
    reset = 1'b0;
    compare_all();

    // Zero-wait memory, decode always ready.
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'h1000);
    repeat (6) cyc(1'b1, 1'b0, 64'h0, 1'b1);
    chk("cnt3", {32'd0, fetch_count}, 64'd3);
    chk("addr_100c", imem_addr, 64'h100C);

    // Redirect during a slow fetch: data dropped, next request at the target.
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    cyc(1'b0, 1'b1, 64'h2000, 1'b0);
    chk("held_addr", imem_addr, 64'h100C);
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    chk("kill_valid", {63'd0, inst_valid}, 64'd0);
    chk("kill_addr", imem_addr, 64'h2000);
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    chk("redir_inst_pc", inst_pc, 64'h2000);

    // Decode stall then accept.
    repeat (5) cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("stall_valid", {63'd0, inst_valid}, 64'd1);
    chk("stall_req", {63'd0, imem_req}, 64'd0);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("stall_cnt", {32'd0, fetch_count}, 64'd4);
    chk("stall_next", imem_addr, 64'h2004);

    // Misaligned redirect in VALID with ready: not counted.
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    cyc(1'b0, 1'b1, 64'h3002, 1'b1);
    chk("mis_pulse", {63'd0, misalign_err}, 64'd1);
    chk("mis_addr", imem_addr, 64'h3000);
    chk("mis_cnt", {32'd0, fetch_count}, 64'd4);
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    chk("mis_clear", {63'd0, misalign_err}, 64'd0);

    // PC wrap past the top of the address space.
    cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 64'h0, 1'b1);
    cyc(1'b0, 1'b0, 64'h0, 1'b1);
    chk("wrap_addr", imem_addr, 64'h0);
    chk("wrap_cnt", {32'd0, fetch_count}, 64'd5);

    // Asynchronous reset mid-wait, then a stale ack.
    cyc(1'b0, 1'b0, 64'h0, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_req", {63'd0, imem_req}, 64'd0);
    chk("arst_addr", imem_addr, RV);
    chk("arst_cnt", {32'd0, fetch_count}, 64'd0);
    model_reset();
    imem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 1'b0, 64'h0, 1'b1);
    chk("stale_valid", {63'd0, inst_valid}, 64'd0);
    chk("stale_addr", imem_addr, RV);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        a, rv, rd;
      logic [63:0] rp;
      a  = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rp[63:32] = 32'hFFFF_FFFF;
      rd = ($urandom_range(0, 9) < 7);
      cyc(a, rv, rp, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
